// File: rtl/uart_msg_framer_pkg.sv
// Shared definitions for the UART message framer: start delimiter, default payload
// depth and the state encodings of the framer and the byte loader.
// Optional trailing checksum is enabled with the MSG_CHECKSUM_EN macro.
package uart_msg_framer_pkg;

  localparam logic [7:0] SP_START         = 8'h7E;
  localparam int         MSG_DATAMAXBYTES = 10;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HEAD = 3'd1,
    S_BCNT = 3'd2,
    S_BODY = 3'd3,
    S_CSUM = 3'd4,
    S_DONE = 3'd5
  } frame_state_t;

  typedef enum logic [1:0] {
    L_IDLE     = 2'd0,
    L_LOAD     = 2'd1,
    L_ACK_LOW  = 2'd2,
    L_ACK_HIGH = 2'd3
  } load_state_t;

endpackage

// File: rtl/uart_msg_framer_if.sv
// Byte-load link between the framer (master) and the uart TX half (slave).
interface uart_msg_framer_if;
  logic       ld_tx_data;
  logic [7:0] tx_data;
  logic       tx_enable;
  logic       tx_empty;

  modport master (output ld_tx_data, output tx_data, output tx_enable, input tx_empty);
  modport slave  (input ld_tx_data, input tx_data, input tx_enable, output tx_empty);
endinterface

// File: rtl/uart_msg_framer_byte_loader.sv
// Hands one byte to the uart: waits for an empty holding register, strobes
// ld_tx_data for one cycle, then waits for the uart to take the byte (tx_empty
// low) and finish with it (tx_empty high) before reporting acceptance.
module uart_byte_loader
  import uart_msg_framer_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_byte_valid,
  input  logic [7:0] i_byte_in,
  input  logic       i_tx_empty,
  output logic       o_byte_accepted,
  output logic       o_ld_tx_data,
  output logic [7:0] o_tx_data
);

  load_state_t r_state;
  load_state_t w_state_next;
  logic [7:0]  r_tx_data;
  logic        w_start_load;

  assign w_start_load = (r_state == L_IDLE) && i_byte_valid && i_tx_empty;

  // Handshake state register.
  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= L_IDLE;
    else         r_state <= w_state_next;
  end

  // Capture the byte on entry to LOAD so tx_data stays stable for the whole handshake.
  always_ff @(posedge i_clk) begin
    if (i_reset)           r_tx_data <= 8'h00;
    else if (w_start_load) r_tx_data <= i_byte_in;
  end

  // Next-state and strobe decode.
  always_comb begin
    w_state_next    = r_state;
    o_byte_accepted = 1'b0;
    o_ld_tx_data    = 1'b0;
    case (r_state)
      L_IDLE:     if (w_start_load) w_state_next = L_LOAD;
      L_LOAD: begin
        o_ld_tx_data = 1'b1;
        w_state_next = L_ACK_LOW;
      end
      L_ACK_LOW:  if (!i_tx_empty) w_state_next = L_ACK_HIGH;
      L_ACK_HIGH: if (i_tx_empty) begin
        o_byte_accepted = 1'b1;
        w_state_next    = L_IDLE;
      end
      default:    w_state_next = L_IDLE;
    endcase
  end

  assign o_tx_data = r_tx_data;

endmodule

// File: rtl/uart_msg_framer.sv
// Frames the buffered payload as START(0x7E), BCNT, BODY[0..BCNT-1] and feeds it
// byte by byte to the uart through uart_byte_loader.
// MSG_CHECKSUM_EN adds a trailing byte: sum mod 256 of BCNT and all BODY bytes.
module uart_msg_framer
  import uart_msg_framer_pkg::*;
#(
  parameter int DATAMAXBYTES = MSG_DATAMAXBYTES,
  parameter int ADDR_W       = 4
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [7:0]        i_wr_data,
  input  logic [7:0]        i_nbytes,
  input  logic              i_send,
  output logic              o_busy,
  output logic              o_done,
  uart_msg_framer_if.master u_uart
);

`ifdef MSG_CHECKSUM_EN
  localparam frame_state_t S_AFTER_BODY = S_CSUM;
`else
  localparam frame_state_t S_AFTER_BODY = S_DONE;
`endif

  frame_state_t      r_state;
  frame_state_t      w_state_next;
  logic [7:0]        r_buf [DATAMAXBYTES];
  logic [7:0]        r_len;
  logic [ADDR_W-1:0] r_idx;
  logic [7:0]        w_len_clamped;
  logic [7:0]        w_buf_rd;
  logic              w_last_body;
  logic              w_accept;
  logic              w_wr_in_range;
  logic              w_byte_valid;
  logic [7:0]        w_byte;
  logic              w_byte_accepted;
`ifdef MSG_CHECKSUM_EN
  logic [7:0]        r_csum;
`endif

  assign o_busy         = (r_state != S_IDLE) && (r_state != S_DONE);
  assign o_done         = (r_state == S_DONE);
  assign u_uart.tx_enable = o_busy;

  assign w_accept      = (r_state == S_IDLE) && i_send;
  assign w_len_clamped = (i_nbytes > 8'(DATAMAXBYTES)) ? 8'(DATAMAXBYTES) : i_nbytes;
  assign w_wr_in_range = (32'(i_wr_addr) < DATAMAXBYTES);
  assign w_buf_rd      = r_buf[r_idx];
  assign w_last_body   = (8'(r_idx) == (r_len - 8'd1));

  // Payload buffer; frozen while a frame is in flight so the frame is self-consistent.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < DATAMAXBYTES; i++) r_buf[i] <= 8'h00;
    end else if (i_wr_en && !o_busy && w_wr_in_range) begin
      r_buf[i_wr_addr] <= i_wr_data;
    end
  end

  // Frame state register.
  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_next;
  end

  // Length latch, body index and optional running checksum.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_len  <= 8'h00;
      r_idx  <= '0;
`ifdef MSG_CHECKSUM_EN
      r_csum <= 8'h00;
`endif
    end else begin
      if (w_accept) begin
        r_len <= w_len_clamped;
        r_idx <= '0;
      end
      if ((r_state == S_BODY) && w_byte_accepted) r_idx <= r_idx + ADDR_W'(1);
`ifdef MSG_CHECKSUM_EN
      if ((r_state == S_BCNT) && w_byte_accepted) r_csum <= r_len;
      if ((r_state == S_BODY) && w_byte_accepted) r_csum <= r_csum + w_buf_rd;
`endif
    end
  end

  // Byte sequencing: pick the byte for the current state, advance on acceptance.
  always_comb begin
    w_state_next = r_state;
    w_byte_valid = 1'b0;
    w_byte       = SP_START;
    case (r_state)
      S_IDLE: if (i_send) w_state_next = S_HEAD;
      S_HEAD: begin
        w_byte_valid = 1'b1;
        w_byte       = SP_START;
        if (w_byte_accepted) w_state_next = S_BCNT;
      end
      S_BCNT: begin
        w_byte_valid = 1'b1;
        w_byte       = r_len;
        if (w_byte_accepted) w_state_next = (r_len == 8'd0) ? S_AFTER_BODY : S_BODY;
      end
      S_BODY: begin
        w_byte_valid = 1'b1;
        w_byte       = w_buf_rd;
        if (w_byte_accepted && w_last_body) w_state_next = S_AFTER_BODY;
      end
`ifdef MSG_CHECKSUM_EN
      S_CSUM: begin
        w_byte_valid = 1'b1;
        w_byte       = r_csum;
        if (w_byte_accepted) w_state_next = S_DONE;
      end
`endif
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  uart_byte_loader u_loader (
    .i_clk           (i_clk),
    .i_reset         (i_reset),
    .i_byte_valid    (w_byte_valid),
    .i_byte_in       (w_byte),
    .i_tx_empty      (u_uart.tx_empty),
    .o_byte_accepted (w_byte_accepted),
    .o_ld_tx_data    (u_uart.ld_tx_data),
    .o_tx_data       (u_uart.tx_data)
  );

endmodule

// File: tb/tb_uart_msg_framer.sv
// Directed bench for uart_msg_framer with a uart model that holds tx_empty low
// for 5 cycles after each load and a scoreboard of expected frame bytes.
module tb_uart_msg_framer;

  localparam int DMAX = 10;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic [7:0] nbytes;
  logic       send;
  logic       busy;
  logic       done;

  int         n_cmp  = 0;
  int         n_fail = 0;
  int         n_ld   = 0;
  int         n_done = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mdl_buf[DMAX];
  bit         frame_active;

  uart_msg_framer_if u_if();

  uart_msg_framer #(.DATAMAXBYTES(DMAX), .ADDR_W(4)) dut (
    .i_clk     (clk),
    .i_reset   (reset),
    .i_wr_en   (wr_en),
    .i_wr_addr (wr_addr),
    .i_wr_data (wr_data),
    .i_nbytes  (nbytes),
    .i_send    (send),
    .o_busy    (busy),
    .o_done    (done),
    .u_uart    (u_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model of the payload buffer: writes land only while no frame is in flight.
  task automatic mdl_write(input int a, input logic [7:0] d);
    if (!frame_active && a < DMAX) mdl_buf[a] = d;
  endtask

  task automatic push_frame(input int n);
    int         len;
    logic [7:0] s;
    len = (n > DMAX) ? DMAX : n;
    s   = 8'(len);
    exp_q.push_back(8'h7E);
    exp_q.push_back(8'(len));
    for (int i = 0; i < len; i++) begin
      exp_q.push_back(mdl_buf[i]);
      s = s + mdl_buf[i];
    end
`ifdef MSG_CHECKSUM_EN
    exp_q.push_back(s);
`endif
  endtask

  task automatic wr(input int a, input logic [7:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 4'(a); wr_data = d;
    mdl_write(a, d);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic send_frame(input int n, input bit do_wr, input int wa, input logic [7:0] wd);
    @(negedge clk);
    nbytes = 8'(n); send = 1'b1;
    if (do_wr) begin
      wr_en = 1'b1; wr_addr = 4'(wa); wr_data = wd;
      mdl_write(wa, wd);
    end
    push_frame(n);
    frame_active = 1'b1;
    @(negedge clk);
    send = 1'b0; wr_en = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    bit got;
    got = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin got = 1'b1; break; end
    end
    chk({tag, "_done_seen"}, 32'(got), 1);
    chk({tag, "_queue_drained"}, 32'(exp_q.size()), 0);
    if (!got) exp_q.delete();
    frame_active = 1'b0;
  endtask

  // Uart model and scoreboard: compare every load against the queue, pace tx_empty.
  initial begin : uart_model
    logic [7:0] e;
    int         hold;
    bit         done_prev;
    u_if.tx_empty = 1'b1;
    hold      = 0;
    done_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (u_if.ld_tx_data === 1'b1) begin
        n_ld++;
        chk("ld_has_expect", 32'(exp_q.size() != 0), 1);
        chk("tx_enable_eq_busy", 32'(u_if.tx_enable), 32'(busy));
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          $display("tx byte %02h (expected %02h)", u_if.tx_data, e);
          chk("tx_byte", 32'(u_if.tx_data), 32'(e));
        end
        u_if.tx_empty = 1'b0;
        hold = 5;
      end else if (hold > 0) begin
        hold--;
        if (hold == 0) u_if.tx_empty = 1'b1;
      end
      if (done === 1'b1) begin
        n_done++;
        chk("done_busy_low", 32'(busy), 0);
        chk("done_single_cycle", 32'(done_prev), 0);
      end
      done_prev = done;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int d0;
    int l0;
    bit got;
    bit seen;
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    nbytes = '0; send = 1'b0; frame_active = 1'b0;
    for (int i = 0; i < DMAX; i++) mdl_buf[i] = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_ld", 32'(u_if.ld_tx_data), 0);
    chk("rst_tx_data", 32'(u_if.tx_data), 0);
    chk("rst_tx_enable", 32'(u_if.tx_enable), 0);

    // 3-byte payload; last byte written in the same cycle as send.
    d0 = n_done;
    wr(0, 8'h11);
    wr(1, 8'h22);
    send_frame(3, 1'b1, 2, 8'h33);
    chk("t1_busy_after_send", 32'(busy), 1);
    @(negedge clk);
    chk("t1_first_ld_latency", 32'(u_if.ld_tx_data), 1);
    wait_done("t1", 600);
    repeat (2) @(negedge clk);
    chk("t1_done_count", 32'(n_done - d0), 1);

    // Empty payload: header and BCNT only.
    d0 = n_done;
    send_frame(0, 1'b0, 0, 8'h00);
    wait_done("t2", 600);
    repeat (2) @(negedge clk);
    chk("t2_done_count", 32'(n_done - d0), 1);

    // Oversize length clamps to DMAX; out-of-range write dropped.
    for (int i = 0; i < DMAX; i++) wr(i, 8'hA0 + 8'(i));
    wr(12, 8'hAA);
    d0 = n_done;
    send_frame(15, 1'b0, 0, 8'h00);
    wait_done("t3", 1500);
    repeat (2) @(negedge clk);
    chk("t3_done_count", 32'(n_done - d0), 1);

    // send and wr_en mid-frame are ignored.
    d0 = n_done;
    l0 = n_ld;
    send_frame(3, 1'b0, 0, 8'h00);
    got = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (n_ld >= l0 + 2) begin got = 1'b1; break; end
    end
    chk("t4_progress", 32'(got), 1);
    @(negedge clk);
    send = 1'b1; nbytes = 8'd5; wr_en = 1'b1; wr_addr = 4'd0; wr_data = 8'h99;
    mdl_write(0, 8'h99);
    @(negedge clk);
    send = 1'b0; wr_en = 1'b0;
    wait_done("t4", 600);
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (busy === 1'b1) seen = 1'b1;
    end
    chk("t4_no_second_frame", 32'(seen), 0);
    chk("t4_done_count", 32'(n_done - d0), 1);

    // send during DONE is ignored, send one cycle later starts a frame.
    d0 = n_done;
    send_frame(1, 1'b0, 0, 8'h00);
    wait_done("t4b", 600);
    nbytes = 8'd0; send = 1'b1;
    push_frame(0);
    frame_active = 1'b1;
    @(negedge clk);
    chk("t4b_send_in_done_ignored", 32'(busy), 0);
    @(negedge clk);
    chk("t4b_send_after_done_accepted", 32'(busy), 1);
    send = 1'b0;
    wait_done("t4c", 600);
    repeat (2) @(negedge clk);
    chk("t4b_done_count", 32'(n_done - d0), 2);

    // Reset during BODY aborts; buffer cleared; next frame starts at the header.
    l0 = n_ld;
    send_frame(3, 1'b0, 0, 8'h00);
    got = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (n_ld >= l0 + 3) begin got = 1'b1; break; end
    end
    chk("t5_progress", 32'(got), 1);
    reset = 1'b1;
    exp_q.delete();
    frame_active = 1'b0;
    for (int i = 0; i < DMAX; i++) mdl_buf[i] = 8'h00;
    @(negedge clk);
    reset = 1'b0;
    chk("t5_busy", 32'(busy), 0);
    chk("t5_done", 32'(done), 0);
    chk("t5_ld", 32'(u_if.ld_tx_data), 0);
    chk("t5_tx_data", 32'(u_if.tx_data), 0);
    chk("t5_tx_enable", 32'(u_if.tx_enable), 0);
    send_frame(2, 1'b0, 0, 8'h00);
    wait_done("t5", 600);

`ifdef MSG_CHECKSUM_EN
    // Checksum covers BCNT and body: 0x02 + 0xFF + 0x02 = 0x03.
    wr(0, 8'hFF);
    wr(1, 8'h02);
    send_frame(2, 1'b0, 0, 8'h00);
    wait_done("t6", 600);
`endif

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
